// File: rtl/muldiv_seq.sv
// Sequential 64-bit multiply / divide unit: shift-add MUL, restoring DIVU/REMU on a shared external ALU.
// Define MULDIV_SIGNED_EN to make ops DIV/REM signed; otherwise they alias DIVU/REMU.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_result,
    output logic        busy,
    input  logic        flush,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [5:0]  cnt_q;
    logic [63:0] x_q;    // multiplicand, or dividend shifting out / quotient shifting in
    logic [63:0] y_q;    // multiplier, or divisor
    logic [63:0] acc_q;  // product accumulator, or partial remainder
    logic [63:0] res_q;

    logic        accept, is_mul, is_rem, req_mul, req_rem, div0, ovf;
    logic [63:0] a_mag, b_mag, spec_res;
    logic [63:0] sh_rem, acc_d, x_d, y_d, quo_fin, rem_fin, fin_d;
    logic        carry, ge;

    assign req_ready   = rst_n & (state_q == IDLE) & ~flush;
    assign accept      = req_valid & req_ready;
    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == DONE);
    assign resp_result = res_q;

    assign is_mul  = (op_q == 3'b000);
    assign is_rem  = (op_q == 3'b010) || (op_q == 3'b101);
    assign req_mul = (req_op == 3'b000);
    assign req_rem = (req_op == 3'b010) || (req_op == 3'b101);
    assign div0    = !req_mul && (req_b == '0);

`ifdef MULDIV_SIGNED_EN
    logic sgn, sa, sb, negq_q, negr_q;
    assign sgn     = req_op[2];
    assign sa      = sgn & req_a[63];
    assign sb      = sgn & req_b[63];
    assign a_mag   = sa ? -req_a : req_a;
    assign b_mag   = sb ? -req_b : req_b;
    assign ovf     = sgn && !req_mul && (req_a == 64'h8000_0000_0000_0000) && (req_b == '1);
    assign quo_fin = negq_q ? -x_d : x_d;
    assign rem_fin = negr_q ? -acc_d : acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (accept) begin
            negq_q <= sa ^ sb;
            negr_q <= sa;
        end
    end
`else
    assign a_mag   = req_a;
    assign b_mag   = req_b;
    assign ovf     = 1'b0;
    assign quo_fin = x_d;
    assign rem_fin = acc_d;
`endif

    // Results that bypass CALC: divide-by-zero and the signed overflow case.
    assign spec_res = div0 ? (req_rem ? req_a : '1)
                           : (req_rem ? 64'd0 : 64'h8000_0000_0000_0000);

    assign carry  = acc_q[63];
    assign sh_rem = {acc_q[62:0], x_q[63]};
    assign ge     = carry | (sh_rem >= y_q);

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 4'b0000;
        if (state_q == CALC) begin
            if (is_mul) begin
                alu_a  = acc_q;
                alu_b  = x_q;
                alu_op = 4'b0010;
            end else begin
                alu_a  = sh_rem;
                alu_b  = y_q;
                alu_op = 4'b0110;
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        if (is_mul) begin
            acc_d = y_q[0] ? alu_result : acc_q;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
        end else begin
            acc_d = ge ? alu_result : sh_rem;
            x_d   = {x_q[62:0], ge};
        end
        fin_d = is_mul ? acc_d : (is_rem ? rem_fin : quo_fin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q  <= req_op;
                    cnt_q <= '0;
                    x_q   <= a_mag;
                    y_q   <= b_mag;
                    acc_q <= '0;
                    if (div0 || ovf) begin
                        res_q   <= spec_res;
                        state_q <= DONE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 6'd1;
                    acc_q <= acc_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    if (cnt_q == 6'd63) begin
                        res_q   <= fin_d;
                        state_q <= DONE;
                    end
                end
                DONE: if (resp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: driver pushes hand-computed results, negedge monitor pops and checks.
module tb_muldiv_seq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [2:0]  req_op = '0;
    logic [63:0] req_a = '0, req_b = '0;
    logic        resp_valid, resp_ready = 1'b1;
    logic [63:0] resp_result;
    logic        busy, flush = 1'b0;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
        string       name;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a, b, e;
        int          lat;
        string       name;
    } vec_t;
    vec_t vecs[$];

    int checks = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare value and latency when a response appears; retire on handshake.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (resp_valid && !prev_v) begin
                if (sbq.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
                else begin
                    chk({sbq[0].name, "_res"}, resp_result, sbq[0].res);
                    chk({sbq[0].name, "_lat"}, 64'(cyc - sbq[0].acc + 1), 64'(sbq[0].lat));
                end
            end
            if (resp_valid && resp_ready && sbq.size() > 0) void'(sbq.pop_front());
            prev_v = resp_valid;
        end
    end

    task automatic start(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input string name, output int acc_cyc);
        int n;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk({name, "_ready_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] e, input int lat, input string name);
        exp_t x;
        int   ac;
        start(op, a, b, name, ac);
        x.res = e; x.acc = ac; x.lat = lat; x.name = name;
        sbq.push_back(x);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk({name, "_resp_timeout"}, 64'd0, 64'd1);
            sbq.delete();
        end
    endtask

    function automatic void add(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] e, input int lat, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.e = e; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bc, ac, n;

        add(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65, "mul_neg1x3");
        add(3'b000, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 65, "mul_wrap");
        add(3'b001, 64'd100, 64'd7, 64'd14, 65, "divu_100_7");
        add(3'b010, 64'd100, 64'd7, 64'd2, 65, "remu_100_7");
        add(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65, "divu_max_1");
        add(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65, "divu_big");
        add(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 65, "remu_big");
        add(3'b010, 64'd7, 64'd100, 64'd7, 65, "remu_small");
        add(3'b010, 64'd5, 64'd0, 64'd5, 1, "remu_div0");
        add(3'b100, 64'd20, 64'd3, 64'd6, 65, "div_20_3");
        add(3'b101, 64'd20, 64'd3, 64'd2, 65, "rem_20_3");
`ifdef MULDIV_SIGNED_EN
        add(3'b100, -64'sd20, 64'd3, -64'sd6, 65, "div_m20_3");
        add(3'b101, -64'sd20, 64'd3, -64'sd2, 65, "rem_m20_3");
        add(3'b100, 64'd20, -64'sd3, -64'sd6, 65, "div_20_m3");
        add(3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, "div_ovf");
        add(3'b101, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_ovf");
        add(3'b101, -64'sd5, 64'd0, -64'sd5, 1, "rem_div0");
`else
        add(3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, "div_alias_big");
        add(3'b101, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65, "rem_alias_big");
`endif

        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", resp_result, 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MUL 7x6: 65-cycle latency and busy span
        issue(3'b000, 64'd7, 64'd6, 64'd42, 65, "mul_7x6");
        bc = 0;
        @(negedge clk);
        while (busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", 64'(bc), 64'd65);
        wait_done("mul_7x6");

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat, vecs[i].name);
            wait_done(vecs[i].name);
        end

        // divide by zero bypasses the ALU entirely
        issue(3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_div0");
        @(negedge clk);
        chk("div0_alu_op", 64'(alu_op), 64'd0);
        wait_done("divu_div0");

        // DIVU uses SUB on the shared ALU while calculating
        issue(3'b001, 64'd81, 64'd9, 64'd9, 65, "divu_81_9");
        repeat (5) @(negedge clk);
        chk("divu_alu_op", 64'(alu_op), 64'd6);
        wait_done("divu_81_9");

        // Backpressure in DONE: result holds, no new request accepted
        resp_ready = 1'b0;
        issue(3'b001, 64'd100, 64'd7, 64'd14, 65, "divu_hold");
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) begin
            @(negedge clk);
            chk("hold_result", resp_result, 64'd14);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        wait_done("divu_hold");

        // Flush mid-CALC: back to IDLE, no response
        start(3'b000, 64'd9, 64'd9, "flush_mul", ac);
        repeat (30) @(negedge clk);
        flush = 1'b1;
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_resp_valid", 64'(resp_valid), 64'd0);
        flush = 1'b0;
        repeat (80) @(negedge clk);
        issue(3'b000, 64'd3, 64'd5, 64'd15, 65, "mul_after_flush");
        wait_done("mul_after_flush");

        // Asynchronous reset mid-CALC
        start(3'b000, 64'd7, 64'd6, "rst_mul", ac);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_resp_valid", 64'(resp_valid), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        chk("arst_result", resp_result, 64'd0);
        chk("arst_alu_a", alu_a, 64'd0);
        chk("arst_alu_op", 64'(alu_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("arst_idle", 64'(busy), 64'd0);
        issue(3'b010, 64'd100, 64'd7, 64'd2, 65, "remu_after_rst");
        wait_done("remu_after_rst");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
